// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit ids, packetizer states and address field helpers.
package noc_pkg;

   localparam int unsigned ADDR_W    = 4;
   localparam int unsigned FLIT_ID_W = 3;

   localparam logic [FLIT_ID_W-1:0] FLIT_HEADER = 3'b001;
   localparam logic [FLIT_ID_W-1:0] FLIT_BODY   = 3'b010;
   localparam logic [FLIT_ID_W-1:0] FLIT_TAIL   = 3'b100;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      PAY,
      ZTAIL
   } state_t;

   function automatic logic [1:0] addr_x(input logic [ADDR_W-1:0] addr);
      return addr[1:0];
   endfunction

   function automatic logic [1:0] addr_y(input logic [ADDR_W-1:0] addr);
      return addr[3:2];
   endfunction

   function automatic logic [ADDR_W-1:0] make_addr(input logic [1:0] y, input logic [1:0] x);
      return {y, x};
   endfunction

endpackage

// File: rtl/ni_credit_counter.sv
// Credit counter for the router input buffer; flags credits returned beyond its depth.
module ni_credit_counter #(
   parameter int unsigned CREDITS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic consume,
   input  logic credit_in,
   output logic has_credit,
   output logic credit_err
);

   localparam int unsigned CNT_W = $clog2(CREDITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

   logic [CNT_W-1:0] cnt;

   assign has_credit = (cnt != '0);

   // A simultaneous consume and return cancel out; overflow is held and reported.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= CNT_MAX;
         credit_err <= 1'b0;
      end else if (consume && has_credit && !credit_in) begin
         cnt <= cnt - CNT_W'(1);
      end else if (credit_in && !consume) begin
         if (cnt == CNT_MAX) begin
            credit_err <= 1'b1;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/ni_packetizer.sv
// NI transmit side: core message -> HEADER/BODY/TAIL flit stream with credit flow control.
module ni_packetizer
   import noc_pkg::*;
#(
   parameter int unsigned DATA_W  = 29,
   parameter int unsigned LEN_W   = 8,
   parameter int unsigned CREDITS = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_W-1:0]           cur_addr_rst,
   input  logic                        msg_valid,
   output logic                        msg_ready,
   input  logic [ADDR_W-1:0]           msg_dst,
   input  logic [LEN_W-1:0]            msg_len,
   input  logic                        data_valid,
   output logic                        data_ready,
   input  logic [DATA_W-1:0]           data_in,
   output logic                        flit_valid,
   output logic [DATA_W+FLIT_ID_W-1:0] flit_out,
   input  logic                        credit_in,
   output logic                        credit_err
);

   localparam int unsigned FLIT_W = DATA_W + FLIT_ID_W;

   state_t              state, state_d;
   logic [ADDR_W-1:0]   cur_addr;
   logic [ADDR_W-1:0]   dst_q, dst_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic [DATA_W-1:0]   hdr_payload;
   logic [FLIT_W-1:0]   flit_d;
   logic                emit;
   logic                has_credit;

   ni_credit_counter #(
      .CREDITS (CREDITS)
   ) u_credit (
      .clk        (clk),
      .rst        (rst),
      .consume    (emit),
      .credit_in  (credit_in),
      .has_credit (has_credit),
      .credit_err (credit_err)
   );

   // State, latched descriptor and registered flit output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cur_addr   <= make_addr(addr_y(cur_addr_rst), addr_x(cur_addr_rst));
         dst_q      <= '0;
         len_q      <= '0;
         rem_q      <= '0;
         flit_valid <= 1'b0;
         flit_out   <= '0;
      end else begin
         state      <= state_d;
         dst_q      <= dst_d;
         len_q      <= len_d;
         rem_q      <= rem_d;
         flit_valid <= emit;
         flit_out   <= flit_d;
      end
   end

   // Next state, flit selection and handshake readies.
   always_comb begin
      state_d     = state;
      dst_d       = dst_q;
      len_d       = len_q;
      rem_d       = rem_q;
      flit_d      = flit_out;
      emit        = 1'b0;
      msg_ready   = 1'b0;
      data_ready  = 1'b0;

      hdr_payload                       = '0;
      hdr_payload[ADDR_W-1:0]           = cur_addr;
      hdr_payload[2*ADDR_W-1:ADDR_W]    = dst_q;
      hdr_payload[2*ADDR_W +: LEN_W]    = len_q;

      case (state)
         IDLE: begin
            msg_ready = 1'b1;
            if (msg_valid) begin
               dst_d   = msg_dst;
               len_d   = msg_len;
               state_d = HDR;
            end
         end
         HDR: begin
            if (has_credit) begin
               emit   = 1'b1;
               flit_d = {FLIT_HEADER, hdr_payload};
               if (len_q == '0) begin
                  state_d = ZTAIL;
               end else begin
                  rem_d   = len_q;
                  state_d = PAY;
               end
            end
         end
         PAY: begin
            data_ready = has_credit;
            if (has_credit && data_valid) begin
               emit  = 1'b1;
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  flit_d  = {FLIT_TAIL, data_in};
                  state_d = IDLE;
               end else begin
                  flit_d = {FLIT_BODY, data_in};
               end
            end
         end
         ZTAIL: begin
            if (has_credit) begin
               emit    = 1'b1;
               flit_d  = {FLIT_TAIL, DATA_W'(0)};
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Nothing is offered or consumed while reset is held.
      if (rst) begin
         msg_ready  = 1'b0;
         data_ready = 1'b0;
         emit       = 1'b0;
      end
   end

endmodule

// File: tb/tb_ni_packetizer.sv
// Self-checking bench for ni_packetizer: directed scenarios plus randomized traffic vs a packet-level model.
module tb_ni_packetizer;

   localparam int unsigned DATA_W  = 29;
   localparam int unsigned LEN_W   = 8;
   localparam int unsigned CREDITS = 4;
   localparam int unsigned FLIT_W  = DATA_W + 3;

   localparam logic [2:0] ID_HDR  = 3'b001;
   localparam logic [2:0] ID_BODY = 3'b010;
   localparam logic [2:0] ID_TAIL = 3'b100;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [3:0]        cur_addr_rst = 4'h0;
   logic              msg_valid = 1'b0;
   logic              msg_ready;
   logic [3:0]        msg_dst = 4'h0;
   logic [LEN_W-1:0]  msg_len = '0;
   logic              data_valid = 1'b0;
   logic              data_ready;
   logic [DATA_W-1:0] data_in = '0;
   logic              flit_valid;
   logic [FLIT_W-1:0] flit_out;
   logic              credit_in = 1'b0;
   logic              credit_err;

   always #5 clk = ~clk;

   ni_packetizer #(
      .DATA_W  (DATA_W),
      .LEN_W   (LEN_W),
      .CREDITS (CREDITS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cur_addr_rst (cur_addr_rst),
      .msg_valid    (msg_valid),
      .msg_ready    (msg_ready),
      .msg_dst      (msg_dst),
      .msg_len      (msg_len),
      .data_valid   (data_valid),
      .data_ready   (data_ready),
      .data_in      (data_in),
      .flit_valid   (flit_valid),
      .flit_out     (flit_out),
      .credit_in    (credit_in),
      .credit_err   (credit_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Packet-level model state
   logic [FLIT_W-1:0] exp_q[$];
   logic [DATA_W-1:0] word_q[$];
   logic [DATA_W-1:0] pend_words[$];
   logic [FLIT_W-1:0] seen_q[$];
   int                avail = CREDITS;
   logic              err_exp = 1'b0;
   logic [3:0]        my_addr = 4'h0;

   // Stimulus controls
   logic              off_valid = 1'b0;
   logic [3:0]        off_dst = 4'h0;
   logic [LEN_W-1:0]  off_len = '0;
   int                dv_pct = 100;
   int                cin_mode = 0;   // 0 none, 1 random, 2 echo each flit
   logic              force_cin = 1'b0;
   logic              force_err = 1'b0;
   logic              next_rst = 1'b1;
   logic [3:0]        next_addr = 4'h0;

   // Values that were present at the last rising edge
   logic              hs_msg = 1'b0, hs_data = 1'b0, cin_drv = 1'b0, rst_drv = 1'b1;
   logic [3:0]        addr_drv = 4'h0;

   int nflits = 0, run = 0, maxrun = 0;

   task automatic accept_msg();
      int hp;
      hp = int'(off_len) * 256 + int'(off_dst) * 16 + int'(my_addr);
      exp_q.push_back({ID_HDR, DATA_W'(hp)});
      if (off_len == 0) begin
         exp_q.push_back({ID_TAIL, DATA_W'(0)});
      end else begin
         for (int i = 0; i < int'(off_len); i++) begin
            exp_q.push_back({(i == int'(off_len) - 1) ? ID_TAIL : ID_BODY, pend_words[i]});
            word_q.push_back(pend_words[i]);
         end
      end
      off_valid = 1'b0;
   endtask

   task automatic step();
      logic [FLIT_W-1:0] e;
      @(negedge clk);
      if (rst_drv) begin
         exp_q.delete();
         word_q.delete();
         avail   = CREDITS;
         err_exp = 1'b0;
         my_addr = addr_drv;
         run     = 0;
         check("rst_flit_valid", flit_valid, 1'b0);
      end else begin
         if (hs_msg) accept_msg();
         if (hs_data) void'(word_q.pop_front());
         if (flit_valid) begin
            nflits++;
            run++;
            seen_q.push_back(flit_out);
            check("flit_with_credit", avail > 0, 1'b1);
            if (exp_q.size() == 0) begin
               check("flit_unexpected", flit_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("flit", flit_out, e);
            end
         end else begin
            run = 0;
         end
         if (flit_valid && cin_drv) begin
         end else if (flit_valid) begin
            avail--;
         end else if (cin_drv) begin
            if (avail == CREDITS) err_exp = 1'b1;
            else avail++;
         end
      end
      if (run > maxrun) maxrun = run;
      check("credit_err", credit_err, err_exp);
      check("msg_ready", msg_ready, !rst_drv && exp_q.size() == 0);
      check("data_ready_no_words", data_ready && (rst_drv || word_q.size() == 0), 1'b0);

      rst          = next_rst;
      cur_addr_rst = next_rst ? next_addr : 4'($urandom);
      msg_valid    = off_valid;
      msg_dst      = off_valid ? off_dst : 4'($urandom);
      msg_len      = off_valid ? off_len : LEN_W'($urandom);
      data_valid   = (word_q.size() > 0) && ($urandom_range(0, 99) < dv_pct);
      data_in      = data_valid ? word_q[0] : DATA_W'($urandom);
      case (cin_mode)
         1:       credit_in = (avail < CREDITS) && ($urandom_range(0, 99) < 50);
         2:       credit_in = flit_valid && (avail < CREDITS);
         default: credit_in = 1'b0;
      endcase
      if (force_cin) begin
         credit_in = (avail < CREDITS);
         force_cin = 1'b0;
      end
      if (force_err) begin
         credit_in = 1'b1;
         force_err = 1'b0;
      end
      #1;
      hs_msg   = msg_valid && msg_ready;
      hs_data  = data_valid && data_ready;
      cin_drv  = credit_in;
      rst_drv  = rst;
      addr_drv = cur_addr_rst;
   endtask

   task automatic offer(input logic [3:0] d, input logic [LEN_W-1:0] l, input bit seq);
      off_valid = 1'b1;
      off_dst   = d;
      off_len   = l;
      pend_words.delete();
      for (int i = 0; i < int'(l); i++)
         pend_words.push_back(seq ? DATA_W'(i + 1) : DATA_W'($urandom));
   endtask

   task automatic do_reset(input logic [3:0] a);
      next_rst  = 1'b1;
      next_addr = a;
      step();
      step();
      next_rst  = 1'b0;
   endtask

   task automatic run_idle(input int budget);
      int k = 0;
      while ((off_valid || exp_q.size() > 0) && k < budget) begin
         step();
         k++;
      end
      check("drain_timeout", off_valid || exp_q.size() > 0, 1'b0);
   endtask

   task automatic wait_flits(input int n, input int budget);
      int k = 0;
      while (nflits < n && k < budget) begin
         step();
         k++;
      end
      check("wait_flits_timeout", nflits >= n, 1'b1);
   endtask

   initial begin
      // T1: basic 3-word packet, back-to-back, consumes all credits
      do_reset(4'h5);
      dv_pct = 100; cin_mode = 0;
      seen_q.delete(); maxrun = 0;
      offer(4'hA, 8'd3, 1'b1);
      run_idle(50);
      check("t1_count", seen_q.size(), 4);
      check("t1_header", seen_q[0], {ID_HDR, 29'h3A5});
      check("t1_body1", seen_q[1], {ID_BODY, 29'd1});
      check("t1_tail", seen_q[3], {ID_TAIL, 29'd3});
      check("t1_back_to_back", maxrun, 4);
      nflits = 0;
      offer(4'h1, 8'd1, 1'b0);
      repeat (10) step();
      check("t1_credits_exhausted", nflits, 0);

      // T2: stall at zero credits, resume on returned credits
      do_reset(4'h5);
      nflits = 0;
      offer(4'h3, 8'd6, 1'b0);
      repeat (20) step();
      check("t2_stall_flits", nflits, 4);
      check("t2_stall_valid", flit_valid, 1'b0);
      check("t2_stall_dready", data_ready, 1'b0);
      force_cin = 1'b1; step();
      force_cin = 1'b1; step();
      repeat (10) step();
      check("t2_resume_flits", nflits, 6);
      cin_mode = 1;
      run_idle(100);
      check("t2_total_flits", nflits, 7);

      // T3: zero-length packet
      do_reset(4'h5);
      cin_mode = 1; seen_q.delete();
      offer(4'h0, 8'd0, 1'b0);
      run_idle(50);
      check("t3_count", seen_q.size(), 2);
      check("t3_header", seen_q[0], {ID_HDR, 29'h005});
      check("t3_tail", seen_q[1], {ID_TAIL, 29'd0});

      // T4: credits echoed every flit -> no stall
      do_reset(4'h9);
      cin_mode = 2; maxrun = 0;
      offer(4'h6, 8'd10, 1'b0);
      run_idle(100);
      check("t4_back_to_back", maxrun, 11);
      repeat (3) step();

      // T5: reset mid-packet drops it; next packet starts clean with full credits
      do_reset(4'h2);
      cin_mode = 0; nflits = 0;
      offer(4'hF, 8'd5, 1'b0);
      wait_flits(3, 20);
      next_rst = 1'b1; next_addr = 4'h2;
      step();
      step();
      check("t5_rst_valid", flit_valid, 1'b0);
      check("t5_rst_msg_ready", msg_ready, 1'b0);
      check("t5_rst_data_ready", data_ready, 1'b0);
      next_rst = 1'b0;
      nflits = 0; seen_q.delete();
      offer(4'h7, 8'd6, 1'b0);
      repeat (20) step();
      check("t5_full_credits", nflits, 4);
      check("t5_new_header", seen_q[0], {ID_HDR, 29'h672});
      cin_mode = 1;
      run_idle(100);

      // T6: credit overflow is sticky until reset, count stays at CREDITS
      do_reset(4'h5);
      cin_mode = 0;
      step(); step();
      force_err = 1'b1;
      step(); step();
      check("t6_err_set", credit_err, 1'b1);
      repeat (5) step();
      check("t6_err_sticky", credit_err, 1'b1);
      nflits = 0;
      offer(4'h1, 8'd6, 1'b0);
      repeat (20) step();
      check("t6_credits_capped", nflits, 4);
      do_reset(4'h5);
      check("t6_err_cleared", credit_err, 1'b0);

      // Randomized traffic
      cin_mode = 1; dv_pct = 70;
      for (int m = 0; m < 40; m++) begin
         if (m % 10 == 0) do_reset(4'($urandom));
         offer(4'($urandom), LEN_W'($urandom_range(0, 12)), 1'b0);
         run_idle(1000);
         repeat ($urandom_range(0, 3)) step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
